// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display multiplexer.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;

    // Active-low pin polarity.
    localparam logic SEG_ON  = 1'b0;
    localparam logic SEG_OFF = 1'b1;
    localparam logic AN_ON   = 1'b0;
    localparam logic AN_OFF  = 1'b1;

    // All seven segments dark (g..a).
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Hex glyphs, active low, bits 6:0 = g..a; entry n is digit n.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h27, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg7_hex_dec
    import seg7_pkg::*;
(
    input  logic [3:0]       nib_i,
    output logic [SEG_W-1:0] seg_c_o
);

    // Table lookup of the glyph.
    always_comb begin
        seg_c_o = hex_to_seg(nib_i);
    end

endmodule

// File: rtl/seg7_mux.sv
// Time-multiplexed seven-segment driver with frame-synchronous data update
// and leading-zero suppression.
module seg7_mux
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dots,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_en,
    input  logic                    load,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(REFRESH_DIV - 2);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fd_q, fd_d;
    logic                  pend_q, pend_d;

    // Active set (what is displayed) and pending set (waiting for a frame boundary).
    logic [VAL_W-1:0]      a_val_q, a_val_d, p_val_q, p_val_d;
    logic [NUM_DIGITS-1:0] a_dots_q, a_dots_d, p_dots_q, p_dots_d;
    logic [NUM_DIGITS-1:0] a_blank_q, a_blank_d, p_blank_q, p_blank_d;
    logic                  a_lz_q, a_lz_d, p_lz_q, p_lz_d;

    logic [NUM_DIGITS-1:0] sup_c;
    logic                  zrun_c;
    logic [3:0]            nib_c;
    logic                  dot_c, blk_c, sel_sup_c, in_blank_c;
    logic [SEG_W-1:0]      dec_c;

    // Slot counter and digit index; frame_done is pre-decoded one slot cycle early.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        fd_d = (idx_q == IDX_LAST) && (cnt_q == CNT_PRE);
    end

    // Pending capture on load; active set swaps only on the frame_done cycle.
    always_comb begin
        a_val_d   = a_val_q;
        a_dots_d  = a_dots_q;
        a_blank_d = a_blank_q;
        a_lz_d    = a_lz_q;
        p_val_d   = p_val_q;
        p_dots_d  = p_dots_q;
        p_blank_d = p_blank_q;
        p_lz_d    = p_lz_q;
        pend_d    = pend_q;
        if (load) begin
            p_val_d   = value;
            p_dots_d  = dots;
            p_blank_d = blank;
            p_lz_d    = lz_en;
            pend_d    = 1'b1;
        end
        if (fd_q) begin
            pend_d = 1'b0;
            if (load) begin
                a_val_d   = value;
                a_dots_d  = dots;
                a_blank_d = blank;
                a_lz_d    = lz_en;
            end else if (pend_q) begin
                a_val_d   = p_val_q;
                a_dots_d  = p_dots_q;
                a_blank_d = p_blank_q;
                a_lz_d    = p_lz_q;
            end
        end
    end

    // Leading-zero mask: a digit is suppressed while it and every higher nibble are zero.
    always_comb begin
        sup_c  = '0;
        zrun_c = a_lz_q;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zrun_c   = zrun_c & (a_val_q[4*i +: 4] == 4'h0);
            sup_c[i] = zrun_c;
        end
    end

    // Select the current digit's nibble and attributes.
    always_comb begin
        nib_c     = '0;
        dot_c     = 1'b0;
        blk_c     = 1'b0;
        sel_sup_c = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_c     = a_val_q[4*i +: 4];
                dot_c     = a_dots_q[i];
                blk_c     = a_blank_q[i];
                sel_sup_c = sup_c[i];
            end
        end
    end

    seg7_hex_dec u_dec (
        .nib_i   (nib_c),
        .seg_c_o (dec_c)
    );

    // Pin values for the next cycle, dark during the anode-off window.
    always_comb begin
        in_blank_c = (cnt_q < CNT_BLANK);
        seg_d      = {SEG_OFF, SEG_BLANK};
        an_d       = {NUM_DIGITS{AN_OFF}};
        if (!in_blank_c) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_q == IDX_W'(i)) an_d[i] = AN_ON;
            end
            if (!blk_c) begin
                seg_d = {(dot_c ? SEG_ON : SEG_OFF), (sel_sup_c ? SEG_BLANK : dec_c)};
            end
        end
    end

    // State and output registers; reset leaves the display dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            seg_q     <= {SEG_OFF, SEG_BLANK};
            an_q      <= {NUM_DIGITS{AN_OFF}};
            fd_q      <= 1'b0;
            pend_q    <= 1'b0;
            a_val_q   <= '0;
            a_dots_q  <= '0;
            a_blank_q <= '1;
            a_lz_q    <= 1'b0;
            p_val_q   <= '0;
            p_dots_q  <= '0;
            p_blank_q <= '1;
            p_lz_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            fd_q      <= fd_d;
            pend_q    <= pend_d;
            a_val_q   <= a_val_d;
            a_dots_q  <= a_dots_d;
            a_blank_q <= a_blank_d;
            a_lz_q    <= a_lz_d;
            p_val_q   <= p_val_d;
            p_dots_q  <= p_dots_d;
            p_blank_q <= p_blank_d;
            p_lz_q    <= p_lz_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign pending    = pend_q;
    assign frame_done = fd_q;

endmodule
